// File: rtl/forwarding_hazard_unit_pkg.sv
// forwarding_hazard_unit_pkg: shared widths and operand-mux select encodings
package forwarding_hazard_unit_pkg;
  localparam int NB_REG = 5;
  localparam int NB_SEL = 2;
  localparam logic [NB_SEL-1:0] SEL_REGFILE = 2'b00;
  localparam logic [NB_SEL-1:0] SEL_EXMEM = 2'b01;
  localparam logic [NB_SEL-1:0] SEL_MEMWB = 2'b10;
  localparam logic [NB_SEL-1:0] SEL_IMM = 2'b11;
endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: ID-stage fields in, operand selects and stall out
// HAZARD_STATS_EN adds the stall_count_o counter output.
interface forwarding_hazard_unit_if;
  import forwarding_hazard_unit_pkg::*;
  logic enable_i;
  logic flush_i;
  logic [NB_REG-1:0] id_rs_i;
  logic [NB_REG-1:0] id_rt_i;
  logic id_uses_rt_i;
  logic [NB_REG-1:0] id_wreg_i;
  logic id_regwrite_i;
  logic id_memread_i;
  logic id_alusrc_i;
  logic [NB_SEL-1:0] fwd_a_sel_o;
  logic [NB_SEL-1:0] fwd_b_sel_o;
  logic [NB_SEL-1:0] fwd_st_sel_o;
  logic stall_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_o;
`endif
  modport master (
    output enable_i, flush_i, id_rs_i, id_rt_i, id_uses_rt_i, id_wreg_i,
    output id_regwrite_i, id_memread_i, id_alusrc_i,
`ifdef HAZARD_STATS_EN
    input stall_count_o,
`endif
    input fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o, stall_o
  );
  modport slave (
    input enable_i, flush_i, id_rs_i, id_rt_i, id_uses_rt_i, id_wreg_i,
    input id_regwrite_i, id_memread_i, id_alusrc_i,
`ifdef HAZARD_STATS_EN
    output stall_count_o,
`endif
    output fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o, stall_o
  );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_match.sv
// forwarding_hazard_unit_fwd_match: select code for one source register vs EX/MEM shadows
module forwarding_hazard_unit_fwd_match
  import forwarding_hazard_unit_pkg::*;
(
  input  logic [NB_REG-1:0] src,
  input  logic [NB_REG-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic [NB_REG-1:0] mem_wreg,
  input  logic              mem_regwrite,
  output logic [NB_SEL-1:0] sel
);
  // $0 is hardwired zero; EX is checked first so the newest producer wins
  always_comb begin
    sel = (src == '0) ? SEL_REGFILE :
          (ex_regwrite && ex_wreg == src) ? SEL_EXMEM :
          (mem_regwrite && mem_wreg == src) ? SEL_MEMWB : SEL_REGFILE;
  end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: registered EX operand forwarding selects and load-use stall
// Optional HAZARD_STATS_EN adds a saturating count of stalled pipeline advances.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
(
  input logic clock_i,
  input logic reset_n_i,
  forwarding_hazard_unit_if.slave bus
);
  logic [NB_REG-1:0] ex_wreg_q, mem_wreg_q;
  logic ex_regwrite_q, ex_memread_q, mem_regwrite_q;
  logic hazard, bubble;
  logic [NB_SEL-1:0] rs_sel, rt_sel;
  assign hazard = ex_memread_q && ex_wreg_q != '0 &&
                  (ex_wreg_q == bus.id_rs_i || (bus.id_uses_rt_i && ex_wreg_q == bus.id_rt_i));
  assign bubble = bus.flush_i || hazard;
  assign bus.stall_o = hazard;
  forwarding_hazard_unit_fwd_match u_rs (
    .src(bus.id_rs_i), .ex_wreg(ex_wreg_q), .ex_regwrite(ex_regwrite_q),
    .mem_wreg(mem_wreg_q), .mem_regwrite(mem_regwrite_q), .sel(rs_sel)
  );
  forwarding_hazard_unit_fwd_match u_rt (
    .src(bus.id_rt_i), .ex_wreg(ex_wreg_q), .ex_regwrite(ex_regwrite_q),
    .mem_wreg(mem_wreg_q), .mem_regwrite(mem_regwrite_q), .sel(rt_sel)
  );
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_wreg_q <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q <= 1'b0;
      mem_wreg_q <= '0;
      mem_regwrite_q <= 1'b0;
      bus.fwd_a_sel_o <= SEL_REGFILE;
      bus.fwd_b_sel_o <= SEL_REGFILE;
      bus.fwd_st_sel_o <= SEL_REGFILE;
    end else if (bus.enable_i) begin
      mem_wreg_q <= ex_wreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      ex_wreg_q <= bubble ? '0 : bus.id_wreg_i;
      ex_regwrite_q <= !bubble && bus.id_regwrite_i;
      ex_memread_q <= !bubble && bus.id_memread_i;
      bus.fwd_a_sel_o <= bubble ? SEL_REGFILE : rs_sel;
      bus.fwd_b_sel_o <= bubble ? SEL_REGFILE : bus.id_alusrc_i ? SEL_IMM : rt_sel;
      bus.fwd_st_sel_o <= bubble ? SEL_REGFILE : rt_sel;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) bus.stall_count_o <= '0;
    else if (bus.enable_i && hazard && bus.stall_count_o != '1) bus.stall_count_o <= bus.stall_count_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed instruction sequences with hand-computed selects and stalls
module tb_forwarding_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  forwarding_hazard_unit_if bus();
  forwarding_hazard_unit dut (.clock_i(clk), .reset_n_i(rst_n), .bus(bus.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic [4:0] wr,
                    input logic rw, input logic mr, input logic as);
    bus.id_rs_i = rs;
    bus.id_rt_i = rt;
    bus.id_uses_rt_i = ur;
    bus.id_wreg_i = wr;
    bus.id_regwrite_i = rw;
    bus.id_memread_i = mr;
    bus.id_alusrc_i = as;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.enable_i = 1'b1;
    bus.flush_i = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("reset_a", bus.fwd_a_sel_o, 2'b00);
    check("reset_b", bus.fwd_b_sel_o, 2'b00);
    check("reset_st", bus.fwd_st_sel_o, 2'b00);
    check("reset_stall", bus.stall_o, 1'b0);
`ifdef HAZARD_STATS_EN
    check("reset_count", bus.stall_count_o, 32'd0);
`endif
    rst_n = 1'b1;
    // add $3,$1,$2
    id(1, 2, 1, 3, 1, 0, 0);
    check("add_nostall", bus.stall_o, 1'b0);
    tick();
    check("add_a", bus.fwd_a_sel_o, 2'b00);
    // sub $4,$3,$5 : $3 in EX
    id(3, 5, 1, 4, 1, 0, 0);
    tick();
    check("sub_a_exmem", bus.fwd_a_sel_o, 2'b01);
    check("sub_b", bus.fwd_b_sel_o, 2'b00);
    // or $6,$1,$3 : $3 now in MEM
    id(1, 3, 1, 6, 1, 0, 0);
    tick();
    check("or_b_memwb", bus.fwd_b_sel_o, 2'b10);
    check("or_st_memwb", bus.fwd_st_sel_o, 2'b10);
    check("or_a", bus.fwd_a_sel_o, 2'b00);
    // lw $2,0($1)
    id(1, 2, 0, 2, 1, 1, 1);
    check("lw_nostall", bus.stall_o, 1'b0);
    tick();
    check("lw_b_imm", bus.fwd_b_sel_o, 2'b11);
    check("lw_st", bus.fwd_st_sel_o, 2'b00);
    // add $6,$2,$7 : load-use
    id(2, 7, 1, 6, 1, 0, 0);
    check("lu_stall", bus.stall_o, 1'b1);
    tick();
    check("lu_bubble_a", bus.fwd_a_sel_o, 2'b00);
    check("lu_stall_clear", bus.stall_o, 1'b0);
    tick();
    check("lu_post_a_memwb", bus.fwd_a_sel_o, 2'b10);
    // $0 writes in EX and MEM, then read $0
    id(1, 0, 0, 0, 1, 0, 1);
    tick();
    id(0, 0, 1, 0, 1, 0, 0);
    tick();
    check("zero_a", bus.fwd_a_sel_o, 2'b00);
    check("zero_b", bus.fwd_b_sel_o, 2'b00);
    check("zero_st", bus.fwd_st_sel_o, 2'b00);
    // lw $0 then use $0 : no stall
    id(1, 0, 0, 0, 1, 1, 1);
    tick();
    id(0, 0, 1, 9, 1, 0, 0);
    check("lw0_nostall", bus.stall_o, 1'b0);
    tick();
    check("lw0_a", bus.fwd_a_sel_o, 2'b00);
    // add $8,$1,$1 ; sw $8,4($9)
    id(1, 1, 1, 8, 1, 0, 0);
    tick();
    id(9, 8, 1, 0, 0, 0, 1);
    tick();
    check("sw_b_imm", bus.fwd_b_sel_o, 2'b11);
    check("sw_st_exmem", bus.fwd_st_sel_o, 2'b01);
    check("sw_a_memwb", bus.fwd_a_sel_o, 2'b10);
    // lw $10 then dependent with flush
    id(1, 10, 0, 10, 1, 1, 1);
    tick();
    check("lw10_b", bus.fwd_b_sel_o, 2'b11);
    id(10, 10, 1, 11, 1, 0, 0);
    bus.flush_i = 1'b1;
    check("flush_stall", bus.stall_o, 1'b1);
    tick();
    bus.flush_i = 1'b0;
    check("flush_a", bus.fwd_a_sel_o, 2'b00);
    check("flush_b", bus.fwd_b_sel_o, 2'b00);
    check("flush_stall_clear", bus.stall_o, 1'b0);
    // lw $12 then dependent while enable low
    id(1, 12, 0, 12, 1, 1, 1);
    tick();
    id(12, 1, 1, 13, 1, 0, 0);
    bus.enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_stall", bus.stall_o, 1'b1);
      check("frz_b", bus.fwd_b_sel_o, 2'b11);
`ifdef HAZARD_STATS_EN
      check("frz_count", bus.stall_count_o, 32'd2);
`endif
    end
    bus.enable_i = 1'b1;
    tick();
    check("thaw_a", bus.fwd_a_sel_o, 2'b00);
    check("thaw_b", bus.fwd_b_sel_o, 2'b00);
    check("thaw_stall", bus.stall_o, 1'b0);
`ifdef HAZARD_STATS_EN
    check("thaw_count", bus.stall_count_o, 32'd3);
`endif
    tick();
    check("thaw_post_a", bus.fwd_a_sel_o, 2'b10);
    // reset mid-stall
    id(1, 14, 0, 14, 1, 1, 1);
    tick();
    id(14, 0, 0, 15, 1, 0, 0);
    check("pre_rst_stall", bus.stall_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", bus.stall_o, 1'b0);
    check("rst_b", bus.fwd_b_sel_o, 2'b00);
`ifdef HAZARD_STATS_EN
    check("rst_count", bus.stall_count_o, 32'd0);
`endif
    id(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", bus.stall_o, 1'b0);
    check("post_rst_a", bus.fwd_a_sel_o, 2'b00);
    check("post_rst_b", bus.fwd_b_sel_o, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
